msrv32_store_buffer: RTL and testbench
======================================

# msrv32_store_buffer

Posted write buffer between the store unit and the data-memory port. It captures each store the store unit issues (word-aligned address, lane-aligned data, byte mask) into a small FIFO, then drains the FIFO to data memory over a req/ack handshake. The pipeline is stalled only when the buffer is full. Loads that hit a word with a pending store are flagged so the pipeline holds them until that store has drained.

## Interface
Parameters:
- DEPTH, 4, number of buffer entries; must be a power of two and at least 2. Pointer width is log2(DEPTH); the occupancy counter is one bit wider.

Ports:
- ms_riscv32_mp_clk_in  input  1  sole clock; all state updates on its rising edge
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset
- st_req_in  input  1  store issue strobe from the store unit (its dmwr_req)
- st_addr_in  input  32  word-aligned store address; bits [1:0] are ignored and stored as 0
- st_data_in  input  32  lane-aligned store data
- st_mask_in  input  4  byte-write mask
- ld_req_in  input  1  load issue strobe from the pipeline
- ld_addr_in  input  32  load address; only bits [31:2] are compared
- mem_ack_in  input  1  data memory accepted the presented write this cycle
- mem_wr_req_out  output  1  write request to data memory
- mem_addr_out  output  32  head-entry address
- mem_data_out  output  32  head-entry data
- mem_mask_out  output  4  head-entry mask
- stall_out  output  1  store refused this cycle; the pipeline must hold it
- ld_hazard_out  output  1  load word matches a pending store
- empty_out  output  1  buffer holds no entries
- count_out  output  log2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular FIFO with registered head/tail pointers and an occupancy counter `count`.
  - Pointers wrap modulo DEPTH.
  - Entries are {addr[31:2], data, mask}.
- **Push:** occurs when st_req_in=1, st_mask_in≠0 and count<DEPTH. The entry is written at the tail, and the tail and count increment.
- **Zero-mask store:** st_req_in=1 with st_mask_in=0 is silently dropped. It does not push and does not stall.
- **Stall:** stall_out = st_req_in & (st_mask_in≠0) & (count==DEPTH). This is combinational.
- **Drain:**
  - mem_wr_req_out = (count≠0).
  - mem_addr_out = {head.addr, 2'b00}; mem_data_out and mem_mask_out come from the head entry.
  - When the buffer is empty, mem_addr_out, mem_data_out and mem_mask_out are all 0.
- **Pop:** occurs when mem_wr_req_out & mem_ack_in. The head and count advance. mem_ack_in is ignored while the buffer is empty.
- **Handshake rule:** the presented head entry is held stable until it is acked. There is no reordering and no merging of entries.
- **Simultaneous push and pop:**
  - When count<DEPTH, both take effect and count is unchanged.
  - When count==DEPTH, the pop takes effect and the push is refused (stall_out=1). The slot frees next cycle.
- **Load hazard:** ld_hazard_out = ld_req_in & OR over all valid entries of (entry.addr == ld_addr_in[31:2]).
  - It is combinational.
  - Validity is derived from head/count, so stale entries never match.
  - The entry being popped in the current cycle still counts as valid.
  - A store being pushed in the current cycle does not yet count.
- empty_out = (count==0); count_out = count.

## Timing
- **Reset** (asynchronous on ms_riscv32_mp_rst_in=1):
  - head, tail and count go to 0; all entries are invalidated.
  - Output values: mem_wr_req_out=0, mem_addr_out/mem_data_out/mem_mask_out=0, stall_out=0 when no store is presented, ld_hazard_out=0, empty_out=1, count_out=0.
- **Reset mid-operation:** all pending stores are discarded. mem_wr_req_out deasserts immediately without waiting for a clock, even if an ack was outstanding.
- **Push-to-request latency:** 1 cycle. A store pushed at edge N is presented with mem_wr_req_out=1 in cycle N+1 (no bypass path).
- **Minimum drain:** one entry per cycle when mem_ack_in is held high.
- **Combinational outputs:** stall_out and ld_hazard_out have zero latency. All other outputs are functions of registered state only.
- **Storage:** entry storage needs no reset; validity comes only from the pointers.

## Test plan
- **Single store:** reset, then push addr 0x0000_1003 / data 0x0000_00AB / mask 4'b0001, with mem_ack_in=1 throughout.
  - Cycle after push: mem_wr_req_out=1, mem_addr_out=0x0000_1000, mem_mask_out=4'b0001.
  - Next cycle: empty_out=1, count_out=0.
- **Fill and backpressure (DEPTH=4):** hold mem_ack_in=0 and push 5 stores.
  - The 5th store sees stall_out=1 and count_out=4.
  - Raise ack for one cycle with the 5th store still presented: stall_out=1 that cycle, and the 5th store is accepted the following cycle.
  - Drain order equals push order.
- **Wrap-around:** push and pop 10 stores alternately, with data 0..9. The memory side observes data 0..9 in order, and count_out never exceeds 2.
- **Load hazard:**
  - Store pending to 0x2000 with ack held low: a load to 0x2002 gives ld_hazard_out=1; a load to 0x2004 gives 0.
  - After ack, the load to 0x2002 gives 0.
- **Zero-mask store and stray ack:** a store with st_mask_in=0 leaves count_out=0, stall_out=0 and mem_wr_req_out=0. mem_ack_in=1 while empty leaves count_out=0.
- **Async reset mid-drain:** with 3 entries pending, pulse reset between clock edges. mem_wr_req_out drops before the next edge, count_out=0, and no further writes appear.

Source files
------------

// File: rtl/msrv32_store_buffer_if.sv
// rtl/msrv32_store_buffer_if.sv - store-unit, load-check and data-memory signals of the store buffer
interface msrv32_store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             st_req_in;
    logic [31:0]      st_addr_in;
    logic [31:0]      st_data_in;
    logic [3:0]       st_mask_in;
    logic             ld_req_in;
    logic [31:0]      ld_addr_in;
    logic             mem_ack_in;
    logic             mem_wr_req_out;
    logic [31:0]      mem_addr_out;
    logic [31:0]      mem_data_out;
    logic [3:0]       mem_mask_out;
    logic             stall_out;
    logic             ld_hazard_out;
    logic             empty_out;
    logic [CNT_W-1:0] count_out;

    modport slave (
        input  st_req_in, st_addr_in, st_data_in, st_mask_in,
        input  ld_req_in, ld_addr_in, mem_ack_in,
        output mem_wr_req_out, mem_addr_out, mem_data_out, mem_mask_out,
        output stall_out, ld_hazard_out, empty_out, count_out
    );

    modport master (
        output st_req_in, st_addr_in, st_data_in, st_mask_in,
        output ld_req_in, ld_addr_in, mem_ack_in,
        input  mem_wr_req_out, mem_addr_out, mem_data_out, mem_mask_out,
        input  stall_out, ld_hazard_out, empty_out, count_out
    );
endinterface

// File: rtl/msrv32_store_buffer.sv
// rtl/msrv32_store_buffer.sv - posted write FIFO between store unit and data memory
module msrv32_store_buffer #(
    parameter int DEPTH = 4
) (
    input logic                  ms_riscv32_mp_clk_in,
    input logic                  ms_riscv32_mp_rst_in,
    msrv32_store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [29:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [3:0]  mask_mem [DEPTH];

    logic full, empty, store_valid, push, pop;
    logic hit;
    logic [PTR_W-1:0] off;
    logic unused_addr_lsbs;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign store_valid = sb.st_req_in & (|sb.st_mask_in);
    assign push        = store_valid & ~full;
    assign pop         = ~empty & sb.mem_ack_in;

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never reset; head/count alone decide which slots are live.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            addr_mem[tail_q] <= sb.st_addr_in[31:2];
            data_mem[tail_q] <= sb.st_data_in;
            mask_mem[tail_q] <= sb.st_mask_in;
        end
    end

    // A slot is live when its distance from head is below count, so the entry
    // being popped this cycle still matches and the one being pushed does not.
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - head_q;
            if (({1'b0, off} < count_q) && (addr_mem[i] == sb.ld_addr_in[31:2]))
                hit = 1'b1;
        end
    end

    assign sb.mem_wr_req_out = ~empty;
    assign sb.mem_addr_out   = empty ? 32'h0 : {addr_mem[head_q], 2'b00};
    assign sb.mem_data_out   = empty ? 32'h0 : data_mem[head_q];
    assign sb.mem_mask_out   = empty ? 4'h0  : mask_mem[head_q];
    assign sb.stall_out      = store_valid & full;
    assign sb.ld_hazard_out  = sb.ld_req_in & hit;
    assign sb.empty_out      = empty;
    assign sb.count_out      = count_q;

    assign unused_addr_lsbs = ^{sb.st_addr_in[1:0], sb.ld_addr_in[1:0]};
endmodule

// File: tb/tb_msrv32_store_buffer.sv
// tb/tb_msrv32_store_buffer.sv - scoreboard bench for msrv32_store_buffer
module tb_msrv32_store_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   pops = 0;
    int   model_cnt = 0;
    logic [67:0] exp_q [$];

    always #5 clk = ~clk;

    msrv32_store_buffer_if #(.DEPTH(DEPTH)) sb_if ();

    msrv32_store_buffer #(.DEPTH(DEPTH)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .sb                   (sb_if.slave)
    );

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Independent occupancy model driven only by the bench's own stimulus.
    always @(posedge clk or posedge rst) begin
        if (rst) model_cnt <= 0;
        else model_cnt <= model_cnt
                        + ((sb_if.st_req_in && sb_if.st_mask_in != 4'h0 && model_cnt < DEPTH) ? 1 : 0)
                        - ((model_cnt != 0 && sb_if.mem_ack_in) ? 1 : 0);
    end

    // Memory-side monitor: sampled mid-cycle, after the negedge stimulus settles.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            check("wr_req", 68'(sb_if.mem_wr_req_out), 68'(model_cnt != 0));
            if (sb_if.mem_wr_req_out && sb_if.mem_ack_in) begin
                check("sb_has_entry", 68'(exp_q.size() != 0), 68'd1);
                if (exp_q.size() != 0) begin
                    check("drain_entry", {sb_if.mem_addr_out, sb_if.mem_data_out, sb_if.mem_mask_out},
                          exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    task automatic drive(input logic req, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic ack,
                         input logic lreq, input logic [31:0] la);
        @(negedge clk);
        sb_if.st_req_in  = req;
        sb_if.st_addr_in = a;
        sb_if.st_data_in = d;
        sb_if.st_mask_in = m;
        sb_if.mem_ack_in = ack;
        sb_if.ld_req_in  = lreq;
        sb_if.ld_addr_in = la;
        if (req && m != 4'h0 && model_cnt < DEPTH)
            exp_q.push_back({a[31:2], 2'b00, d, m});
        #1;
    endtask

    task automatic idle(input logic ack);
        drive(1'b0, 32'h0, 32'h0, 4'h0, ack, 1'b0, 32'h0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) idle(1'b1);
        idle(1'b0);
        check("drained_q", 68'(exp_q.size()), 68'd0);
        check("drained_empty", 68'(sb_if.empty_out), 68'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        sb_if.st_req_in = 1'b0; sb_if.st_addr_in = '0; sb_if.st_data_in = '0; sb_if.st_mask_in = '0;
        sb_if.ld_req_in = 1'b0; sb_if.ld_addr_in = '0; sb_if.mem_ack_in = 1'b0;
        #12;
        check("rst_wr_req", 68'(sb_if.mem_wr_req_out), 68'd0);
        check("rst_bus", {sb_if.mem_addr_out, sb_if.mem_data_out, sb_if.mem_mask_out}, 68'h0);
        check("rst_stall", 68'(sb_if.stall_out), 68'd0);
        check("rst_hazard", 68'(sb_if.ld_hazard_out), 68'd0);
        check("rst_empty", 68'(sb_if.empty_out), 68'd1);
        check("rst_count", 68'(sb_if.count_out), 68'd0);
        rst = 1'b0;

        // Single store with ack held high.
        drive(1'b1, 32'h0000_1003, 32'h0000_00AB, 4'b0001, 1'b1, 1'b0, 32'h0);
        idle(1'b1);
        check("single_req", 68'(sb_if.mem_wr_req_out), 68'd1);
        check("single_addr", 68'(sb_if.mem_addr_out), 68'h0000_1000);
        check("single_mask", 68'(sb_if.mem_mask_out), 68'h1);
        idle(1'b1);
        check("single_empty", 68'(sb_if.empty_out), 68'd1);
        check("single_count", 68'(sb_if.count_out), 68'd0);

        // Fill, backpressure, stall held through a pop cycle.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h200, 32'hA5, 4'h3, 1'b0, 1'b0, 32'h0);
        check("fill_stall", 68'(sb_if.stall_out), 68'd1);
        check("fill_count", 68'(sb_if.count_out), 68'd4);
        drive(1'b1, 32'h200, 32'hA5, 4'h3, 1'b1, 1'b0, 32'h0);
        check("full_pop_stall", 68'(sb_if.stall_out), 68'd1);
        drive(1'b1, 32'h200, 32'hA5, 4'h3, 1'b0, 1'b0, 32'h0);
        check("slot_freed_stall", 68'(sb_if.stall_out), 68'd0);
        check("slot_freed_count", 68'(sb_if.count_out), 68'd3);
        drain_all();

        // Wrap-around: push and pop alternately.
        for (int i = 0; i < 10; i++) begin
            pops = 0;
            drive(1'b1, 32'h400 + 32'(i * 4), 32'(i), 4'hF, 1'b1, 1'b0, 32'h0);
            check("wrap_cnt_le2", 68'(sb_if.count_out <= 2), 68'd1);
            idle(1'b1);
            check("wrap_cnt_le2", 68'(sb_if.count_out <= 2), 68'd1);
            idle(1'b1);
            check("wrap_pop_seen", 68'(pops), 68'd1);
        end
        drain_all();

        // Load hazard.
        drive(1'b1, 32'h3000, 32'h1, 4'hF, 1'b0, 1'b1, 32'h3000);
        check("hz_push_same_cycle", 68'(sb_if.ld_hazard_out), 68'd0);
        drain_all();
        drive(1'b1, 32'h2000, 32'h55, 4'hF, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h2002);
        check("hz_hit", 68'(sb_if.ld_hazard_out), 68'd1);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h2004);
        check("hz_miss", 68'(sb_if.ld_hazard_out), 68'd0);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h2002);
        check("hz_popping", 68'(sb_if.ld_hazard_out), 68'd1);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h2002);
        check("hz_after_ack", 68'(sb_if.ld_hazard_out), 68'd0);

        // Zero-mask store and stray ack.
        drive(1'b1, 32'h5000, 32'hDEAD, 4'h0, 1'b0, 1'b0, 32'h0);
        check("zm_stall", 68'(sb_if.stall_out), 68'd0);
        idle(1'b1);
        check("zm_count", 68'(sb_if.count_out), 68'd0);
        check("zm_req", 68'(sb_if.mem_wr_req_out), 68'd0);
        idle(1'b0);
        check("stray_ack_count", 68'(sb_if.count_out), 68'd0);

        // Asynchronous reset with three entries pending.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h600 + 32'(i * 4), 32'hC0 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        check("pre_rst_count", 68'(sb_if.count_out), 68'd3);
        #3 rst = 1'b1;
        #1;
        check("arst_req", 68'(sb_if.mem_wr_req_out), 68'd0);
        check("arst_count", 68'(sb_if.count_out), 68'd0);
        exp_q.delete();
        #1 rst = 1'b0;
        pops = 0;
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("arst_no_writes", 68'(pops), 68'd0);
        check("arst_empty", 68'(sb_if.empty_out), 68'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
